ste_microwire: RTL and testbench

// - STE Microwire master ($FF8922 MWDATA, $FF8924 MWMASK). Serialises CPU-written

---
 rtl/ste_microwire.sv | 164 ++++++++++++++++
 tb/tb_ste_microwire.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ste_microwire.sv
// ste_microwire -- STE Microwire master (MWDATA at $FF8922, MWMASK at $FF8924).
// Serialises CPU-written 16-bit words to the LMC1992 volume/tone controller.
// The block lives on the clk32 domain beside the shifter and shares its chip select.
//
// Ports:
//   clk32    in   system clock, all flops on the rising edge
//   resb     in   asynchronous active-low reset
//   CS       in   chip select for the $FF89xx region
//   A[5:0]   in   CPU A[6:1]; 6'h11 = MWDATA, 6'h12 = MWMASK
//   RW       in   1 = read, 0 = write
//   UDS_N    in   upper-byte data strobe (active low)
//   LDS_N    in   lower-byte data strobe (active low)
//   DIN      in   CPU write data
//   DOUT     out  read data, 16'hFFFF when not selected for a read
//   MW_CLK   out  Microwire serial clock
//   MW_DATA  out  Microwire serial data
//   MW_EN_N  out  Microwire enable, low during a transfer
//   BUSY     out  high during a transfer
//
// Each bit slot lasts BIT_CLKS cycles. The clock is high for the second half of
// the slot, and only for slots whose (rotating) mask bit is set. Both registers
// rotate left once per slot, so after NBITS slots they hold their written values
// again and software polling either register sees it move.

module ste_microwire #(
   parameter int BIT_CLKS = 32,
   parameter int NBITS    = 16
) (
   input  logic        clk32,
   input  logic        resb,
   input  logic        CS,
   input  logic [5:0]  A,
   input  logic        RW,
   input  logic        UDS_N,
   input  logic        LDS_N,
   input  logic [15:0] DIN,
   output logic [15:0] DOUT,
   output logic        MW_CLK,
   output logic        MW_DATA,
   output logic        MW_EN_N,
   output logic        BUSY
);

   localparam logic [5:0] ADDR_DATA = 6'h11;
   localparam logic [5:0] ADDR_MASK = 6'h12;

   localparam int PW = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
   localparam int BW = (NBITS > 2) ? $clog2(NBITS) : 1;

   localparam logic [PW-1:0] PHASE_LAST  = PW'(BIT_CLKS - 1);
   localparam logic [PW-1:0] PHASE_RISE  = PW'(BIT_CLKS / 2 - 1);
   localparam logic [PW-1:0] PHASE_ONE   = PW'(1);
   localparam logic [BW-1:0] BIT_LAST    = BW'(NBITS - 1);
   localparam logic [BW-1:0] BIT_ONE     = BW'(1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t        state;
   logic [15:0]   data_reg;
   logic [15:0]   mask_reg;
   logic [PW-1:0] phase_cnt;
   logic [BW-1:0] bit_cnt;
   logic          wr_prev;

   logic          sel_data;
   logic          sel_mask;
   logic          wr;
   logic          wr_rise;
   logic [15:0]   data_merged;
   logic [15:0]   mask_merged;

   // Address decode, write strobe and byte-lane merge of the incoming write.
   always_comb begin
      sel_data    = CS & (A == ADDR_DATA);
      sel_mask    = CS & (A == ADDR_MASK);
      wr          = ~RW & (~UDS_N | ~LDS_N) & (sel_data | sel_mask);
      wr_rise     = wr & ~wr_prev;
      data_merged = {(~UDS_N ? DIN[15:8] : data_reg[15:8]),
                     (~LDS_N ? DIN[7:0]  : data_reg[7:0])};
      mask_merged = {(~UDS_N ? DIN[15:8] : mask_reg[15:8]),
                     (~LDS_N ? DIN[7:0]  : mask_reg[7:0])};
   end

   // Reads return the live registers so a polling CPU sees them rotate.
   always_comb begin
      DOUT = 16'hFFFF;
      if (CS && RW) begin
         if (A == ADDR_DATA) begin
            DOUT = data_reg;
         end else if (A == ADDR_MASK) begin
            DOUT = mask_reg;
         end
      end
   end

   // Transfer FSM. Writes are only accepted in IDLE, so a write that lands on
   // the final cycle of a transfer (still SHIFT) is dropped like any busy write.
   // MW_CLK is loaded one cycle ahead of the phase it belongs to, so it is high
   // exactly while the phase counter sits in the upper half of the slot.
   always_ff @(posedge clk32 or negedge resb) begin
      if (!resb) begin
         state     <= IDLE;
         data_reg  <= 16'h0000;
         mask_reg  <= 16'h0000;
         phase_cnt <= '0;
         bit_cnt   <= '0;
         wr_prev   <= 1'b0;
         MW_CLK    <= 1'b0;
         MW_DATA   <= 1'b0;
         MW_EN_N   <= 1'b1;
         BUSY      <= 1'b0;
      end else begin
         wr_prev <= wr;
         case (state)
            IDLE: begin
               if (wr_rise && sel_mask) begin
                  mask_reg <= mask_merged;
               end
               if (wr_rise && sel_data) begin
                  data_reg  <= data_merged;
                  state     <= SHIFT;
                  BUSY      <= 1'b1;
                  MW_EN_N   <= 1'b0;
                  phase_cnt <= '0;
                  bit_cnt   <= '0;
                  MW_CLK    <= 1'b0;
                  MW_DATA   <= 1'b0;
               end
            end
            SHIFT: begin
               if (phase_cnt == '0) begin
                  MW_DATA <= data_reg[15] & mask_reg[15];
               end
               MW_CLK <= mask_reg[15] & (phase_cnt >= PHASE_RISE) &
                         (phase_cnt != PHASE_LAST);
               if (phase_cnt == PHASE_LAST) begin
                  data_reg  <= {data_reg[14:0], data_reg[15]};
                  mask_reg  <= {mask_reg[14:0], mask_reg[15]};
                  phase_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     state   <= IDLE;
                     BUSY    <= 1'b0;
                     MW_EN_N <= 1'b1;
                     MW_CLK  <= 1'b0;
                     MW_DATA <= 1'b0;
                  end else begin
                     bit_cnt <= bit_cnt + BIT_ONE;
                  end
               end else begin
                  phase_cnt <= phase_cnt + PHASE_ONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ste_microwire.sv
// tb_ste_microwire -- self-checking bench for ste_microwire.
// A negedge monitor records every MW_CLK rise (data bit and slot), the number of
// cycles MW_EN_N is low, and BUSY rises. Expected serial streams come from a
// reference model that walks the written mask/data words MSB first and emits a
// bit only for slots whose mask bit is set.

module tb_ste_microwire;

   localparam logic [5:0] ADDR_DATA = 6'h11;
   localparam logic [5:0] ADDR_MASK = 6'h12;
   localparam int         XFER_LEN  = 512;

   logic        clk32;
   logic        resb;
   logic        CS;
   logic [5:0]  A;
   logic        RW;
   logic        UDS_N;
   logic        LDS_N;
   logic [15:0] DIN;
   logic [15:0] DOUT;
   logic        MW_CLK;
   logic        MW_DATA;
   logic        MW_EN_N;
   logic        BUSY;

   int vectors;
   int miscompares;

   int          obs_n;
   logic [15:0] obs_bits;
   logic [15:0] obs_slots;
   int          en_cnt;
   int          busy_rises;
   logic        clk_prev;
   logic        busy_prev;

   ste_microwire #(.BIT_CLKS(32), .NBITS(16)) dut (
      .clk32   (clk32),
      .resb    (resb),
      .CS      (CS),
      .A       (A),
      .RW      (RW),
      .UDS_N   (UDS_N),
      .LDS_N   (LDS_N),
      .DIN     (DIN),
      .DOUT    (DOUT),
      .MW_CLK  (MW_CLK),
      .MW_DATA (MW_DATA),
      .MW_EN_N (MW_EN_N),
      .BUSY    (BUSY)
   );

   initial clk32 = 1'b0;
   always #5 clk32 = ~clk32;

   // Serial-line monitor, sampled on the falling edge away from register updates.
   initial begin
      obs_n = 0; obs_bits = '0; obs_slots = '0; en_cnt = 0; busy_rises = 0;
      clk_prev = 1'b0; busy_prev = 1'b0;
   end

   always @(negedge clk32) begin
      if (MW_CLK && !clk_prev) begin
         int slot;
         slot = en_cnt / 32;
         obs_n = obs_n + 1;
         obs_bits = {obs_bits[14:0], MW_DATA};
         if (slot < 16) obs_slots[15 - slot] = 1'b1;
      end
      if (!MW_EN_N) en_cnt = en_cnt + 1;
      if (BUSY && !busy_prev) busy_rises = busy_rises + 1;
      clk_prev = MW_CLK;
      busy_prev = BUSY;
   end

   task automatic clear_mon();
      obs_n = 0; obs_bits = '0; obs_slots = '0; en_cnt = 0; busy_rises = 0;
   endtask

   // Reference model: bit slot i carries data bit 15-i when mask bit 15-i is set.
   function automatic void model_transfer(input logic [15:0] m, input logic [15:0] d,
                                          output int n, output logic [15:0] bits);
      logic [15:0] acc;
      int          cnt;
      acc = '0;
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (m[15 - i]) begin
            acc = {acc[14:0], d[15 - i]};
            cnt++;
         end
      end
      n = cnt;
      bits = acc;
   endfunction

   task automatic cpu_write(input logic [5:0] addr, input logic [15:0] value,
                            input logic upper, input logic lower);
      @(negedge clk32);
      CS = 1'b1; RW = 1'b0; A = addr; DIN = value;
      UDS_N = ~upper; LDS_N = ~lower;
      @(negedge clk32);
      CS = 1'b0; RW = 1'b1; UDS_N = 1'b1; LDS_N = 1'b1;
   endtask

   task automatic cpu_read(input logic [5:0] addr, output logic [15:0] value);
      @(negedge clk32);
      CS = 1'b1; RW = 1'b1; A = addr;
      #1 value = DOUT;
      #1 CS = 1'b0;
   endtask

   task automatic wait_idle(output logic ok);
      ok = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk32);
         if (!BUSY) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [15:0] rd;
      vectors++;
      if (MW_EN_N !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_en_n: got %b expected 1", MW_EN_N); end
      vectors++;
      if (BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", BUSY); end
      vectors++;
      if (MW_CLK !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mw_clk: got %b expected 0", MW_CLK); end
      vectors++;
      if (MW_DATA !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mw_data: got %b expected 0", MW_DATA); end
      cpu_read(ADDR_MASK, rd);
      vectors++;
      if (rd !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_mask: got %h expected 0000", rd); end
      cpu_read(ADDR_DATA, rd);
      vectors++;
      if (rd !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_data: got %h expected 0000", rd); end
      #1 vectors++;
      if (DOUT !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL dout_unselected: got %h expected ffff", DOUT); end
   endtask

   task automatic test_directed_transfer();
      logic        ok;
      logic [15:0] rd;
      int          exp_n;
      logic [15:0] exp_bits;
      model_transfer(16'h07FF, 16'h04C3, exp_n, exp_bits);
      cpu_write(ADDR_MASK, 16'h07FF, 1'b1, 1'b1);
      clear_mon();
      cpu_write(ADDR_DATA, 16'h04C3, 1'b1, 1'b1);
      // 140 clocks past the start edge: four slots rotated, fifth in progress.
      repeat (140) @(negedge clk32);
      cpu_read(ADDR_DATA, rd);
      vectors++;
      if (rd !== 16'h4C30) begin miscompares++; $display("[TB] FAIL poll_data: got %h expected 4c30", rd); end
      cpu_read(ADDR_MASK, rd);
      vectors++;
      if (rd !== 16'h7FF0) begin miscompares++; $display("[TB] FAIL poll_mask: got %h expected 7ff0", rd); end
      wait_idle(ok);
      vectors++;
      if (!ok) begin miscompares++; $display("[TB] FAIL directed_timeout: BUSY still %b expected 0", BUSY); end
      vectors++;
      if (en_cnt != XFER_LEN) begin miscompares++; $display("[TB] FAIL directed_en_len: got %0d expected %0d", en_cnt, XFER_LEN); end
      vectors++;
      if (obs_n != exp_n) begin miscompares++; $display("[TB] FAIL directed_pulses: got %0d expected %0d", obs_n, exp_n); end
      vectors++;
      if (obs_bits !== exp_bits) begin miscompares++; $display("[TB] FAIL directed_bits: got %h expected %h", obs_bits, exp_bits); end
      vectors++;
      if (obs_slots !== 16'h07FF) begin miscompares++; $display("[TB] FAIL directed_slots: got %h expected 07ff", obs_slots); end
      cpu_read(ADDR_DATA, rd);
      vectors++;
      if (rd !== 16'h04C3) begin miscompares++; $display("[TB] FAIL after_data: got %h expected 04c3", rd); end
      cpu_read(ADDR_MASK, rd);
      vectors++;
      if (rd !== 16'h07FF) begin miscompares++; $display("[TB] FAIL after_mask: got %h expected 07ff", rd); end
   endtask

   task automatic test_random();
      logic        ok;
      logic [15:0] rd;
      logic [15:0] m;
      logic [15:0] d;
      int          exp_n;
      logic [15:0] exp_bits;
      for (int t = 0; t < 6; t++) begin
         m = 16'($urandom);
         d = 16'($urandom);
         model_transfer(m, d, exp_n, exp_bits);
         cpu_write(ADDR_MASK, m, 1'b1, 1'b1);
         clear_mon();
         cpu_write(ADDR_DATA, d, 1'b1, 1'b1);
         wait_idle(ok);
         repeat (2) @(negedge clk32);
         vectors++;
         if (!ok) begin miscompares++; $display("[TB] FAIL rand_timeout[%0d]: BUSY %b expected 0", t, BUSY); end
         vectors++;
         if (en_cnt != XFER_LEN) begin miscompares++; $display("[TB] FAIL rand_en_len[%0d]: got %0d expected %0d", t, en_cnt, XFER_LEN); end
         vectors++;
         if (obs_n != exp_n) begin miscompares++; $display("[TB] FAIL rand_pulses[%0d]: got %0d expected %0d", t, obs_n, exp_n); end
         vectors++;
         if (obs_bits !== exp_bits) begin miscompares++; $display("[TB] FAIL rand_bits[%0d]: got %h expected %h", t, obs_bits, exp_bits); end
         vectors++;
         if (obs_slots !== m) begin miscompares++; $display("[TB] FAIL rand_slots[%0d]: got %h expected %h", t, obs_slots, m); end
         cpu_read(ADDR_DATA, rd);
         vectors++;
         if (rd !== d) begin miscompares++; $display("[TB] FAIL rand_data[%0d]: got %h expected %h", t, rd, d); end
         cpu_read(ADDR_MASK, rd);
         vectors++;
         if (rd !== m) begin miscompares++; $display("[TB] FAIL rand_mask[%0d]: got %h expected %h", t, rd, m); end
      end
   endtask

   task automatic test_busy_write();
      logic        ok;
      logic [15:0] rd;
      logic [15:0] d;
      int          exp_n;
      logic [15:0] exp_bits;
      d = 16'($urandom) & 16'h7FFF;
      model_transfer(16'hFFFF, d, exp_n, exp_bits);
      cpu_write(ADDR_MASK, 16'hFFFF, 1'b1, 1'b1);
      clear_mon();
      cpu_write(ADDR_DATA, d, 1'b1, 1'b1);
      repeat (8 * 32 + 5) @(negedge clk32);
      cpu_write(ADDR_DATA, 16'hFFFF, 1'b1, 1'b1);
      wait_idle(ok);
      repeat (3) @(negedge clk32);
      vectors++;
      if (!ok || busy_rises != 1) begin miscompares++; $display("[TB] FAIL busy_write_rises: got %0d expected 1", busy_rises); end
      vectors++;
      if (obs_bits !== exp_bits) begin miscompares++; $display("[TB] FAIL busy_write_bits: got %h expected %h", obs_bits, exp_bits); end
      cpu_read(ADDR_DATA, rd);
      vectors++;
      if (rd !== d) begin miscompares++; $display("[TB] FAIL busy_write_data: got %h expected %h", rd, d); end
   endtask

   task automatic test_end_collision();
      logic        ok;
      logic [15:0] rd;
      logic [15:0] d;
      d = 16'($urandom);
      cpu_write(ADDR_MASK, 16'h0F0F, 1'b1, 1'b1);
      clear_mon();
      cpu_write(ADDR_DATA, d, 1'b1, 1'b1);
      // The next write's active edge coincides with the final transfer edge.
      repeat (XFER_LEN - 2) @(negedge clk32);
      cpu_write(ADDR_DATA, ~d, 1'b1, 1'b1);
      wait_idle(ok);
      repeat (40) @(negedge clk32);
      vectors++;
      if (!ok || busy_rises != 1) begin miscompares++; $display("[TB] FAIL end_collision_rises: got %0d expected 1", busy_rises); end
      vectors++;
      if (en_cnt != XFER_LEN) begin miscompares++; $display("[TB] FAIL end_collision_en_len: got %0d expected %0d", en_cnt, XFER_LEN); end
      cpu_read(ADDR_DATA, rd);
      vectors++;
      if (rd !== d) begin miscompares++; $display("[TB] FAIL end_collision_data: got %h expected %h", rd, d); end
   endtask

   task automatic test_held_strobe();
      logic ok;
      clear_mon();
      @(negedge clk32);
      CS = 1'b1; RW = 1'b0; A = ADDR_DATA; DIN = 16'hA55A; UDS_N = 1'b0; LDS_N = 1'b0;
      repeat (100) @(negedge clk32);
      CS = 1'b0; RW = 1'b1; UDS_N = 1'b1; LDS_N = 1'b1;
      wait_idle(ok);
      repeat (600) @(negedge clk32);
      vectors++;
      if (!ok || busy_rises != 1) begin miscompares++; $display("[TB] FAIL held_rises: got %0d expected 1", busy_rises); end
      vectors++;
      if (en_cnt != XFER_LEN) begin miscompares++; $display("[TB] FAIL held_en_len: got %0d expected %0d", en_cnt, XFER_LEN); end
   endtask

   task automatic test_byte_and_unused();
      logic [15:0] rd;
      logic [5:0]  addr;
      cpu_write(ADDR_MASK, 16'h1234, 1'b1, 1'b1);
      clear_mon();
      cpu_write(ADDR_MASK, 16'h00AA, 1'b0, 1'b1);
      cpu_read(ADDR_MASK, rd);
      vectors++;
      if (rd !== 16'h12AA) begin miscompares++; $display("[TB] FAIL byte_lower_mask: got %h expected 12aa", rd); end
      cpu_write(ADDR_MASK, 16'h5600, 1'b1, 1'b0);
      cpu_read(ADDR_MASK, rd);
      vectors++;
      if (rd !== 16'h56AA) begin miscompares++; $display("[TB] FAIL byte_upper_mask: got %h expected 56aa", rd); end
      do addr = 6'($urandom); while (addr == ADDR_DATA || addr == ADDR_MASK);
      cpu_write(addr, 16'($urandom), 1'b1, 1'b1);
      cpu_read(addr, rd);
      vectors++;
      if (rd !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL unused_read: got %h expected ffff", rd); end
      cpu_read(ADDR_MASK, rd);
      vectors++;
      if (rd !== 16'h56AA) begin miscompares++; $display("[TB] FAIL unused_mask_kept: got %h expected 56aa", rd); end
      repeat (4) @(negedge clk32);
      vectors++;
      if (busy_rises != 0) begin miscompares++; $display("[TB] FAIL byte_no_start: got %0d busy rises expected 0", busy_rises); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] rd;
      logic [15:0] d;
      d = 16'($urandom) | 16'h0001;
      cpu_write(ADDR_MASK, 16'hFFFF, 1'b1, 1'b1);
      cpu_write(ADDR_DATA, d, 1'b1, 1'b1);
      // Phase 20 of bit slot 6: the serial clock is high here.
      repeat (6 * 32 + 20) @(negedge clk32);
      vectors++;
      if (MW_CLK !== 1'b1 || BUSY !== 1'b1) begin miscompares++; $display("[TB] FAIL pre_reset_state: got clk %b busy %b expected 1 1", MW_CLK, BUSY); end
      #2 resb = 1'b0;
      #1 vectors++;
      if ({MW_CLK, MW_DATA, MW_EN_N, BUSY} !== 4'b0010) begin
         miscompares++;
         $display("[TB] FAIL async_reset_outputs: got %b expected 0010", {MW_CLK, MW_DATA, MW_EN_N, BUSY});
      end
      @(negedge clk32);
      resb = 1'b1;
      cpu_read(ADDR_DATA, rd);
      vectors++;
      if (rd !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_mid_data: got %h expected 0000", rd); end
      cpu_read(ADDR_MASK, rd);
      vectors++;
      if (rd !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_mid_mask: got %h expected 0000", rd); end
      repeat (40) @(negedge clk32);
      vectors++;
      if (BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mid_restart: got busy %b expected 0", BUSY); end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      resb = 1'b0;
      CS = 1'b0; RW = 1'b1; A = 6'h00; UDS_N = 1'b1; LDS_N = 1'b1; DIN = 16'h0000;
      repeat (3) @(negedge clk32);
      test_reset();
      @(negedge clk32);
      resb = 1'b1;
      test_directed_transfer();
      test_random();
      test_busy_write();
      test_end_collision();
      test_held_strobe();
      test_byte_and_unused();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
